// File: rtl/ex_mdu_ctrl_pkg.sv
// Shared MDU types: opcode encoding, sequencer states and a small decode helper.
package mips_pkg;
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    // Prefixed with S_ so the DIV state does not collide with the DIV opcode.
    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'b00,
        MDU_S_MUL  = 2'b01,
        MDU_S_DIV  = 2'b10,
        MDU_S_FIX  = 2'b11
    } mdu_state_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return op[1];
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return !op[0];
    endfunction
endpackage

// File: rtl/ex_mdu_ctrl_if.sv
// EX <-> MDU bundle: issue/operand signals from EX, stall and HI/LO state back.
interface ex_mdu_ctrl_if #(parameter int XLEN = 32);
    import mips_pkg::*;
    logic            mdu_start;
    mdu_op_t         mdu_op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            hilo_rd;
    logic            hi_we;
    logic            lo_we;
    logic            flush;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            done;
    logic            div_by_zero;
    logic [31:0]     op_count;

    modport master (
        output mdu_start, mdu_op, srca, srcb, hilo_rd, hi_we, lo_we, flush,
        input  stall, busy, hi, lo, done, div_by_zero, op_count
    );
    modport slave (
        input  mdu_start, mdu_op, srca, srcb, hilo_rd, hi_we, lo_we, flush,
        output stall, busy, hi, lo, done, div_by_zero, op_count
    );
endinterface

// File: rtl/ex_mdu_ctrl_div_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, trial-subtract.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, div_i};

    // Remainder stays below the divisor, so the restored value always fits XLEN bits.
    always_comb begin
        if (!diff[XLEN]) begin
            rem_o = diff[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/ex_mdu_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, runs a padded multiply or a
// bit-serial restoring divide, and stalls dependent EX instructions until done.
module ex_mdu_ctrl
    import mips_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 4
) (
    input logic          clk,
    input logic          reset,
    ex_mdu_ctrl_if.slave mdu
);
    localparam int CNT_W = $clog2((XLEN > MUL_LAT) ? XLEN : MUL_LAT);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dend_q;
    logic [2*XLEN-1:0] prod_q;
    logic              qneg_q, rneg_q, dz_q;
    logic              done_q, done_d, dzf_q, dzf_d;
    logic [31:0]       opcnt_q, opcnt_d;

    logic              accept, sgn, sdiv, dz_in;
    logic [XLEN-1:0]   a_mag, b_mag, step_rem, step_quo;
    logic signed [2*XLEN-1:0] ma, mb, prod;

    assign accept = (state_q == MDU_S_IDLE) && mdu.mdu_start && !mdu.flush;
    assign sgn    = mdu_is_signed(mdu.mdu_op);
    assign sdiv   = sgn && mdu_is_div(mdu.mdu_op);
    assign dz_in  = mdu_is_div(mdu.mdu_op) && (mdu.srcb == '0);

    // Sign extension to full product width: low 2*XLEN bits equal the XLEN+1 signed product.
    assign ma   = {{XLEN{sgn & mdu.srca[XLEN-1]}}, mdu.srca};
    assign mb   = {{XLEN{sgn & mdu.srcb[XLEN-1]}}, mdu.srcb};
    assign prod = ma * mb;

    assign a_mag = (sdiv && mdu.srca[XLEN-1]) ? -mdu.srca : mdu.srca;
    assign b_mag = (sdiv && mdu.srcb[XLEN-1]) ? -mdu.srcb : mdu.srcb;

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        done_d  = 1'b0;
        dzf_d   = 1'b0;
        opcnt_d = opcnt_q;
        case (state_q)
            MDU_S_IDLE: if (!mdu.flush) begin
                if (mdu.mdu_start) begin
                    if (mdu_is_div(mdu.mdu_op)) begin
                        rem_d = '0;
                        quo_d = a_mag;
                        if (dz_in) state_d = MDU_S_FIX;
                        else begin
                            state_d = MDU_S_DIV;
                            cnt_d   = CNT_W'(XLEN - 1);
                        end
                    end else begin
                        state_d = MDU_S_MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                    end
                end else begin
                    if (mdu.hi_we) hi_d = mdu.srca;
                    if (mdu.lo_we) lo_d = mdu.srca;
                end
            end
            MDU_S_MUL: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                    opcnt_d      = opcnt_q + 32'd1;
                    state_d      = MDU_S_IDLE;
                end else cnt_d = cnt_q - 1'b1;
            end
            MDU_S_DIV: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) state_d = MDU_S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MDU_S_FIX: begin
                done_d  = 1'b1;
                opcnt_d = opcnt_q + 32'd1;
                state_d = MDU_S_IDLE;
                if (dz_q) begin
                    lo_d  = '1;
                    hi_d  = dend_q;
                    dzf_d = 1'b1;
                end else begin
                    lo_d = qneg_q ? -quo_q : quo_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
            end
            default: state_d = MDU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
            dzf_q   <= 1'b0;
            opcnt_q <= '0;
            dvs_q   <= '0;
            dend_q  <= '0;
            prod_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
            dzf_q   <= dzf_d;
            opcnt_q <= opcnt_d;
            if (accept) begin
                dvs_q  <= b_mag;
                dend_q <= mdu.srca;
                prod_q <= prod;
                qneg_q <= sdiv && (mdu.srca[XLEN-1] ^ mdu.srcb[XLEN-1]);
                rneg_q <= sdiv && mdu.srca[XLEN-1];
                dz_q   <= dz_in;
            end
        end
    end

    assign mdu.busy        = (state_q != MDU_S_IDLE);
    assign mdu.stall       = mdu.busy && (mdu.mdu_start || mdu.hilo_rd || mdu.hi_we || mdu.lo_we);
    assign mdu.hi          = hi_q;
    assign mdu.lo          = lo_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = dzf_q;
    assign mdu.op_count    = opcnt_q;
endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Directed bench for ex_mdu_ctrl: multiply/divide results, latency, stall and reset behaviour.
module tb_ex_mdu_ctrl;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_mdu_ctrl_if #(.XLEN(32)) mif ();

    ex_mdu_ctrl #(.XLEN(32), .MUL_LAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b);
        mif.mdu_op    = op;
        mif.srca      = a;
        mif.srcb      = b;
        mif.mdu_start = 1'b1;
        step();
        mif.mdu_start = 1'b0;
    endtask

    // Steps until done (bounded); optionally checks stall every waiting cycle.
    task automatic wait_done(input string tag, input int exp_k, input bit stall_chk);
        int k;
        k = 0;
        do begin
            if (stall_chk) check({tag, "_stall"}, 64'(mif.stall), 64'd1);
            step();
            k++;
        end while (!mif.done && k < 40);
        check({tag, "_lat"}, 64'(k), 64'(exp_k));
        check({tag, "_done"}, 64'(mif.done), 64'd1);
    endtask

    initial begin
        reset         = 1'b1;
        mif.mdu_start = 1'b0;
        mif.mdu_op    = MDU_MULT;
        mif.srca      = '0;
        mif.srcb      = '0;
        mif.hilo_rd   = 1'b0;
        mif.hi_we     = 1'b0;
        mif.lo_we     = 1'b0;
        mif.flush     = 1'b0;
        step();
        step();
        check("rst_hi", 64'(mif.hi), 64'd0);
        check("rst_lo", 64'(mif.lo), 64'd0);
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_stall", 64'(mif.stall), 64'd0);
        check("rst_done", 64'(mif.done), 64'd0);
        check("rst_dz", 64'(mif.div_by_zero), 64'd0);
        check("rst_cnt", 64'(mif.op_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // MULT -3 * 7 = -21
        issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mul_busy", 64'(mif.busy), 64'd1);
        wait_done("mul", 4, 1'b0);
        check("mul_hi", 64'(mif.hi), 64'hFFFF_FFFF);
        check("mul_lo", 64'(mif.lo), 64'hFFFF_FFEB);
        check("mul_cnt", 64'(mif.op_count), 64'd1);
        check("mul_dz", 64'(mif.div_by_zero), 64'd0);

        // DIVU 100/7 with a dependent MFLO held in EX
        issue(MDU_DIVU, 32'd100, 32'd7);
        mif.hilo_rd = 1'b1;
        wait_done("divu", 33, 1'b1);
        check("divu_stall_drop", 64'(mif.stall), 64'd0);
        check("divu_lo", 64'(mif.lo), 64'd14);
        check("divu_hi", 64'(mif.hi), 64'd2);
        mif.hilo_rd = 1'b0;

        // DIV -7/2 -> q=-3, r=-1
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 33, 1'b0);
        check("div_neg_lo", 64'(mif.lo), 64'hFFFF_FFFD);
        check("div_neg_hi", 64'(mif.hi), 64'hFFFF_FFFF);

        // DIV INT_MIN / -1 overflow case
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 33, 1'b0);
        check("div_ovf_lo", 64'(mif.lo), 64'h8000_0000);
        check("div_ovf_hi", 64'(mif.hi), 64'd0);
        check("div_ovf_dz", 64'(mif.div_by_zero), 64'd0);

        // DIVU 5/0
        issue(MDU_DIVU, 32'd5, 32'd0);
        wait_done("dz", 1, 1'b0);
        check("dz_flag", 64'(mif.div_by_zero), 64'd1);
        check("dz_lo", 64'(mif.lo), 64'hFFFF_FFFF);
        check("dz_hi", 64'(mif.hi), 64'd5);
        check("dz_cnt", 64'(mif.op_count), 64'd5);
        step();
        check("dz_pulse", 64'(mif.div_by_zero), 64'd0);

        // MULTU 0x10000 * 0x30000 = 0x3_0000_0000, MTHI queued behind it
        issue(MDU_MULTU, 32'h0001_0000, 32'h0003_0000);
        mif.hi_we = 1'b1;
        mif.srca  = 32'h1234;
        wait_done("mtu", 4, 1'b1);
        check("mtu_stall_drop", 64'(mif.stall), 64'd0);
        check("mtu_hi", 64'(mif.hi), 64'd3);
        check("mtu_lo", 64'(mif.lo), 64'd0);
        step();
        mif.hi_we = 1'b0;
        check("mthi_hi", 64'(mif.hi), 64'h1234);
        check("mthi_lo", 64'(mif.lo), 64'd0);
        check("mthi_cnt", 64'(mif.op_count), 64'd6);

        // Async reset mid-DIV
        issue(MDU_DIV, 32'd100, 32'd7);
        mif.hilo_rd = 1'b1;
        repeat (9) step();
        check("mid_busy", 64'(mif.busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", 64'(mif.busy), 64'd0);
        check("ar_stall", 64'(mif.stall), 64'd0);
        check("ar_hi", 64'(mif.hi), 64'd0);
        check("ar_lo", 64'(mif.lo), 64'd0);
        check("ar_cnt", 64'(mif.op_count), 64'd0);
        mif.hilo_rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();

        // Flushed issue and flushed MTHI in IDLE are ignored
        mif.flush     = 1'b1;
        mif.mdu_op    = MDU_MULT;
        mif.srcb      = 32'd3;
        mif.mdu_start = 1'b1;
        step();
        mif.mdu_start = 1'b0;
        check("fl_busy", 64'(mif.busy), 64'd0);
        mif.hi_we = 1'b1;
        mif.srca  = 32'hABCD;
        step();
        mif.hi_we = 1'b0;
        mif.flush = 1'b0;
        check("fl_hi", 64'(mif.hi), 64'd0);
        repeat (5) step();
        check("fl_done", 64'(mif.done), 64'd0);
        check("fl_cnt", 64'(mif.op_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
